// File: rtl/tx_pkg.sv
// Shared types for the frame transmitter: FSM states, select encodings
// and the Hamming(7,4) encoder used to build the payload chip stream.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        PAYLOAD
    } state_e;

    localparam logic CODE_REP = 1'b0;
    localparam logic CODE_HAM = 1'b1;
    localparam logic LINE_NRZ = 1'b0;
    localparam logic LINE_MAN = 1'b1;

    // Codeword returned in transmit order: {p1, p2, d1, p3, d2, d3, d4}
    function automatic logic [6:0] hamming74(input logic [3:0] nib);
        logic d1, d2, d3, d4;
        d1 = nib[3];
        d2 = nib[2];
        d3 = nib[1];
        d4 = nib[0];
        return {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
    endfunction

endpackage

// File: rtl/line_coder.sv
// Maps one chip plus its position within the chip period onto the line level
// (NRZ or Manchester). Purely combinational; the caller registers the result.
module line_coder
    import tx_pkg::*;
#(
    parameter int SPB   = 2,
    parameter int CYC_W = $clog2(SPB)
) (
    input  logic             chip_i,
    input  logic             line_sel_i,
    input  logic [CYC_W-1:0] cyc_i,
    output logic             line_o
);

    always_comb begin
        line_o = chip_i;
        if (line_sel_i == LINE_MAN) begin
            line_o = (cyc_i < CYC_W'(SPB / 2)) ? chip_i : ~chip_i;
        end
    end

endmodule

// File: rtl/frame_transmitter.sv
// Serial frame transmitter: sync pattern followed by a repetition- or
// Hamming-coded payload, line coded as NRZ or Manchester, SPB cycles per chip.
module frame_transmitter
    import tx_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
    parameter int                SPB          = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              code_sel,
    input  logic              line_sel,
    output logic              data_o,
    output logic              tx_busy,
    output logic              frame_start
);

    localparam int PAY_W  = 3 * DATA_W;
    localparam int MAXC   = (SYNC_W > PAY_W) ? SYNC_W : PAY_W;
    localparam int CHIP_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int CYC_W  = $clog2(SPB);

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(SPB - 1);
    localparam logic [CHIP_W-1:0] SYNC_LAST = CHIP_W'(SYNC_W - 1);
    localparam logic [CHIP_W-1:0] REP_LAST  = CHIP_W'(PAY_W - 1);
    localparam logic [CHIP_W-1:0] HAM_LAST  = CHIP_W'(7 * DATA_W / 4 - 1);

    state_e              state_q, state_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [CHIP_W-1:0]   chip_q, chip_d;
    logic [SYNC_W-1:0]   sync_q, sync_d;
    logic [PAY_W-1:0]    pay_q, pay_d;
    logic                code_q, code_d;
    logic                line_q, line_d;
    logic                data_o_q, data_o_d;
    logic                busy_q, busy_d;
    logic                fs_q, fs_d;
    logic [PAY_W-1:0]    coded;
    logic                chip_val;
    logic                line_val;

    // Whole payload is channel coded at accept time, MSB-aligned, then shifted out
    always_comb begin
        coded = '0;
        if (code_sel == CODE_HAM) begin
            for (int n = 0; n < DATA_W / 4; n++) begin
                coded[PAY_W-1-7*n -: 7] = hamming74(data_i[DATA_W-1-4*n -: 4]);
            end
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                coded[PAY_W-1-3*i -: 3] = {3{data_i[DATA_W-1-i]}};
            end
        end
    end

    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        chip_d  = chip_q;
        sync_d  = sync_q;
        pay_d   = pay_q;
        code_d  = code_q;
        line_d  = line_q;
        fs_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = SYNC;
                    cyc_d   = '0;
                    chip_d  = '0;
                    sync_d  = SYNC_PATTERN;
                    pay_d   = coded;
                    code_d  = code_sel;
                    line_d  = line_sel;
                    fs_d    = 1'b1;
                end
            end
            SYNC: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (chip_q == SYNC_LAST) begin
                        state_d = PAYLOAD;
                        chip_d  = '0;
                    end else begin
                        chip_d = chip_q + CHIP_W'(1);
                        sync_d = sync_q << 1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            PAYLOAD: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (chip_q == ((code_q == CODE_HAM) ? HAM_LAST : REP_LAST)) begin
                        state_d = IDLE;
                        chip_d  = '0;
                    end else begin
                        chip_d = chip_q + CHIP_W'(1);
                        pay_d  = pay_q << 1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Output is computed from next-state values so data_o lines up with the state it reflects
        chip_val = (state_d == SYNC) ? sync_d[SYNC_W-1] : pay_d[PAY_W-1];
        busy_d   = (state_d != IDLE);
        data_o_d = busy_d ? line_val : 1'b0;
    end

    line_coder #(
        .SPB   (SPB),
        .CYC_W (CYC_W)
    ) u_line_coder (
        .chip_i     (chip_val),
        .line_sel_i (line_d),
        .cyc_i      (cyc_d),
        .line_o     (line_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            chip_q   <= '0;
            sync_q   <= '0;
            pay_q    <= '0;
            code_q   <= CODE_REP;
            line_q   <= LINE_NRZ;
            data_o_q <= 1'b0;
            busy_q   <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            chip_q   <= chip_d;
            sync_q   <= sync_d;
            pay_q    <= pay_d;
            code_q   <= code_d;
            line_q   <= line_d;
            data_o_q <= data_o_d;
            busy_q   <= busy_d;
            fs_q     <= fs_d;
        end
    end

    assign data_o      = data_o_q;
    assign tx_busy     = busy_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed bench for frame_transmitter: SPB=2 instance for most scenarios,
// SPB=4 instance for the Manchester scaling case.
module tb_frame_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_i;
    logic       in_valid, in_valid4;
    logic       code_sel, line_sel;
    logic       in_ready, data_o, tx_busy, frame_start;
    logic       in_ready4, data_o4, tx_busy4, frame_start4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    frame_transmitter #(.DATA_W(8), .SYNC_W(8), .SYNC_PATTERN(8'hA5), .SPB(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_i      (data_i),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .code_sel    (code_sel),
        .line_sel    (line_sel),
        .data_o      (data_o),
        .tx_busy     (tx_busy),
        .frame_start (frame_start)
    );

    frame_transmitter #(.DATA_W(8), .SYNC_W(8), .SYNC_PATTERN(8'hA5), .SPB(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .data_i      (data_i),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .code_sel    (code_sel),
        .line_sel    (line_sel),
        .data_o      (data_o4),
        .tx_busy     (tx_busy4),
        .frame_start (frame_start4)
    );

    // Called at a falling edge with the selected instance idle. Offers one word,
    // then checks every cycle of the frame against the hand-written chip list
    // and the idle cycle that follows. hold keeps in_valid asserted afterwards.
    task automatic watch_frame(input logic [7:0] d, input logic cs, input logic ls,
                               input logic [63:0] chips, input int n, input int spb,
                               input bit hold, input string nm);
        logic od, ob, ori, ofs, ch, ex;
        int   zrun, zmax, c, ph;
        data_i   = d;
        code_sel = cs;
        line_sel = ls;
        if (spb == 4) in_valid4 = 1'b1;
        else          in_valid  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            in_valid  = 1'b0;
            in_valid4 = 1'b0;
        end
        zrun = 0;
        zmax = 0;
        for (int k = 0; k < n * spb; k++) begin
            @(negedge clk);
            if (k == 10) data_i = ~d;
            c  = k / spb;
            ph = k % spb;
            ch = chips[n-1-c];
            ex = ls ? ((ph < spb / 2) ? ch : ~ch) : ch;
            od  = (spb == 4) ? data_o4      : data_o;
            ob  = (spb == 4) ? tx_busy4     : tx_busy;
            ori = (spb == 4) ? in_ready4    : in_ready;
            ofs = (spb == 4) ? frame_start4 : frame_start;
            n_cmp++;
            if (od !== ex) begin
                n_bad++;
                $display("FAIL %s data_o cycle %0d: got %b want %b", nm, k, od, ex);
            end
            n_cmp++;
            if (ob !== 1'b1) begin
                n_bad++;
                $display("FAIL %s tx_busy cycle %0d: got %b want 1", nm, k, ob);
            end
            n_cmp++;
            if (ori !== 1'b0) begin
                n_bad++;
                $display("FAIL %s in_ready cycle %0d: got %b want 0", nm, k, ori);
            end
            n_cmp++;
            if (ofs !== (k == 0)) begin
                n_bad++;
                $display("FAIL %s frame_start cycle %0d: got %b want %b", nm, k, ofs, (k == 0));
            end
            zrun = (od === 1'b0) ? zrun + 1 : 0;
            if (zrun > zmax) zmax = zrun;
        end
        if (ls && spb == 2) begin
            n_cmp++;
            if (zmax > 2) begin
                n_bad++;
                $display("FAIL %s manchester zero run: got %0d want <=2", nm, zmax);
            end
        end
        @(negedge clk);
        od  = (spb == 4) ? data_o4   : data_o;
        ob  = (spb == 4) ? tx_busy4  : tx_busy;
        ori = (spb == 4) ? in_ready4 : in_ready;
        n_cmp++;
        if ({od, ob, ori} !== 3'b001) begin
            n_bad++;
            $display("FAIL %s post-frame idle {data_o,tx_busy,in_ready}: got %b want 001",
                     nm, {od, ob, ori});
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        data_i    = 8'h00;
        code_sel  = 1'b0;
        line_sel  = 1'b0;
        #7;
        n_cmp++;
        if ({in_ready, data_o, tx_busy, frame_start} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_state {in_ready,data_o,tx_busy,frame_start}: got %b want 1000",
                     {in_ready, data_o, tx_busy, frame_start});
        end
        n_cmp++;
        if ({in_ready4, data_o4, tx_busy4, frame_start4} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_state_spb4: got %b want 1000",
                     {in_ready4, data_o4, tx_busy4, frame_start4});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rep_nrz();
        watch_frame(8'hC3, 1'b0, 1'b0, {32'h0, 8'hA5, 24'b111111000000000000111111},
                    32, 2, 1'b0, "rep_nrz_c3");
    endtask

    task automatic test_ham_nrz();
        watch_frame(8'hB4, 1'b1, 1'b0, {42'h0, 8'hA5, 14'b0110011_1001100},
                    22, 2, 1'b0, "ham_nrz_b4");
    endtask

    task automatic test_ham_manchester();
        watch_frame(8'hB4, 1'b1, 1'b1, {42'h0, 8'hA5, 14'b0110011_1001100},
                    22, 2, 1'b0, "ham_man_b4");
    endtask

    task automatic test_back_to_back();
        watch_frame(8'h00, 1'b0, 1'b0, {32'h0, 8'hA5, 24'h000000},
                    32, 2, 1'b1, "b2b_first_00");
        watch_frame(8'hFF, 1'b0, 1'b0, {32'h0, 8'hA5, 24'hFFFFFF},
                    32, 2, 1'b0, "b2b_second_ff");
    endtask

    task automatic test_reset_mid_frame();
        data_i   = 8'hC3;
        code_sel = 1'b0;
        line_sel = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (tx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_busy_before: got %b want 1", tx_busy);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, data_o, tx_busy, frame_start} !== 4'b1000) begin
            n_bad++;
            $display("FAIL midreset_async {in_ready,data_o,tx_busy,frame_start}: got %b want 1000",
                     {in_ready, data_o, tx_busy, frame_start});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({in_ready, data_o, tx_busy} !== 3'b100) begin
                n_bad++;
                $display("FAIL midreset_no_resume cycle %0d: got %b want 100",
                         k, {in_ready, data_o, tx_busy});
            end
        end
        watch_frame(8'hC3, 1'b0, 1'b0, {32'h0, 8'hA5, 24'b111111000000000000111111},
                    32, 2, 1'b0, "after_reset_c3");
    endtask

    task automatic test_spb4_manchester();
        watch_frame(8'hB4, 1'b1, 1'b1, {42'h0, 8'hA5, 14'b0110011_1001100},
                    22, 4, 1'b0, "spb4_ham_man_b4");
    endtask

    initial begin
        test_reset();
        test_rep_nrz();
        test_ham_nrz();
        test_ham_manchester();
        test_back_to_back();
        test_reset_mid_frame();
        test_spb4_manchester();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
